bin2bcd_seq: RTL and testbench



---
 rtl/bin2bcd_pkg.sv | 15 +
 rtl/bin2bcd_seq_bcd_digit_adj.sv | 12 +
 rtl/bin2bcd_seq.sv | 95 +++++++++
 tb/tb_bin2bcd_seq.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential double-dabble converter.
package bin2bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t ADJ_THRESH = 4'd5;
  localparam bcd_digit_t ADJ_ADD    = 4'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } bin2bcd_state_t;

endpackage

// File: rtl/bin2bcd_seq_bcd_digit_adj.sv
// Single-digit add-3 correction applied before each shift step.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  bcd_digit_t din,
  output bcd_digit_t dout
);

  // Max input is 9, so the result is at most 12 and never carries.
  assign dout = (din >= ADJ_THRESH) ? bcd_digit_t'(din + ADJ_ADD) : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock, valid/ready on both sides.
// Define BIN2BCD_SIGNED_EN to treat bin as two's complement and report the sign on neg.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  ovf
);

  localparam int CW = $clog2(BIN_W + 1);

  bin2bcd_state_t state, state_nxt;

  logic [CW-1:0]                cnt;
  logic [BIN_W-1:0]             sr;
  logic [BIN_W-1:0]             mag;
  logic                         sgn;
  bcd_digit_t [DIGITS-1:0]      dig;
  bcd_digit_t [DIGITS-1:0]      adj;
  logic [4*DIGITS:0]            shl;

`ifdef BIN2BCD_SIGNED_EN
  // Negating the most negative value wraps to itself, which reads as 2^(BIN_W-1) unsigned.
  assign sgn = bin[BIN_W-1];
  assign mag = sgn ? -bin : bin;
`else
  assign sgn = 1'b0;
  assign mag = bin;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (dig[g]),
      .dout (adj[g])
    );
  end

  // MSB of shl is the bit pushed out of the top digit.
  assign shl = {adj, sr[BIN_W-1]};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)        state_nxt = CONV;
      CONV:    if (cnt == CW'(1))   state_nxt = DONE;
      DONE:    if (out_ready)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
      dig   <= '0;
      neg   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          sr  <= mag;
          neg <= sgn;
          dig <= '0;
          ovf <= 1'b0;
          cnt <= CW'(BIN_W);
        end
        CONV: begin
          sr  <= {sr[BIN_W-2:0], 1'b0};
          dig <= shl[4*DIGITS-1:0];
          ovf <= ovf | shl[4*DIGITS];
          cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign bcd       = dig;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench: default 10-bit/4-digit instance plus a 2-digit instance for overflow.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_neg, a_ovf;
  logic [9:0]  a_bin;
  logic [15:0] a_bcd;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_neg, b_ovf;
  logic [9:0]  b_bin;
  logic [7:0]  b_bcd;

  int vectors = 0;
  int errs    = 0;
  int n;

  always #5 clk = ~clk;

  bin2bcd_seq u0 (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .bin(a_bin),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .bcd(a_bcd), .neg(a_neg), .ovf(a_ovf)
  );

  bin2bcd_seq #(.BIN_W(10), .DIGITS(2)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .bin(b_bin),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .bcd(b_bcd), .neg(b_neg), .ovf(b_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive an operand on u0, take the accept edge, then count edges until out_valid.
  task automatic a_conv(input logic [9:0] v, output int cyc);
    a_bin = v;
    a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    cyc = 0;
    while (!a_out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic b_conv(input logic [9:0] v, output int cyc);
    b_bin = v;
    b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    cyc = 0;
    while (!b_out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_out_ready = 1'b1; a_bin = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_bin = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(a_in_ready),  32'd1);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_bcd",       32'(a_bcd),       32'h0);
    chk("rst_neg",       32'(a_neg),       32'd0);
    chk("rst_ovf",       32'(a_ovf),       32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

`ifndef BIN2BCD_SIGNED_EN
    // 1023: latency and full-scale value
    a_conv(10'd1023, n);
    chk("lat_1023", 32'(n), 32'd10);
    chk("bcd_1023", 32'(a_bcd), 32'h1023);
    chk("ovf_1023", 32'(a_ovf), 32'd0);
    chk("neg_1023", 32'(a_neg), 32'd0);
    @(posedge clk); #1;
    chk("xfer_ov", 32'(a_out_valid), 32'd0);
    chk("xfer_ir", 32'(a_in_ready),  32'd1);

    // 0 then 999 back-to-back
    a_conv(10'd0, n);
    chk("bcd_0", 32'(a_bcd), 32'h0000);
    chk("ovf_0", 32'(a_ovf), 32'd0);
    a_bin = 10'd999;
    a_in_valid = 1'b1;
    @(posedge clk); #1;
    chk("b2b_ir_after_xfer", 32'(a_in_ready), 32'd1);
    chk("b2b_ov_after_xfer", 32'(a_out_valid), 32'd0);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    chk("b2b_accepted", 32'(a_in_ready), 32'd0);
    n = 0;
    while (!a_out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("lat_999", 32'(n), 32'd10);
    chk("bcd_999", 32'(a_bcd), 32'h0999);
    @(posedge clk); #1;

    // backpressure: hold output for 5 cycles with ignored input pulses
    a_out_ready = 1'b0;
    a_conv(10'd321, n);
    chk("bcd_321", 32'(a_bcd), 32'h0321);
    for (int i = 0; i < 5; i++) begin
      a_bin = 10'd5;
      a_in_valid = (i % 2 == 0);
      @(posedge clk); #1;
      chk("hold_ov",  32'(a_out_valid), 32'd1);
      chk("hold_ir",  32'(a_in_ready),  32'd0);
      chk("hold_bcd", 32'(a_bcd),       32'h0321);
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rel_ov", 32'(a_out_valid), 32'd0);
    chk("rel_ir", 32'(a_in_ready),  32'd1);

    // reset mid-conversion
    a_bin = 10'd700;
    a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_ir",  32'(a_in_ready),  32'd1);
    chk("mid_rst_ov",  32'(a_out_valid), 32'd0);
    chk("mid_rst_bcd", 32'(a_bcd),       32'h0);
    chk("mid_rst_ovf", 32'(a_ovf),       32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    a_conv(10'd512, n);
    chk("lat_512", 32'(n), 32'd10);
    chk("bcd_512", 32'(a_bcd), 32'h0512);
    @(posedge clk); #1;
`else
    a_conv(10'h200, n);
    chk("s_lat_m512", 32'(n), 32'd10);
    chk("s_neg_m512", 32'(a_neg), 32'd1);
    chk("s_bcd_m512", 32'(a_bcd), 32'h0512);
    @(posedge clk); #1;
    a_conv(10'h3FF, n);
    chk("s_neg_m1", 32'(a_neg), 32'd1);
    chk("s_bcd_m1", 32'(a_bcd), 32'h0001);
    @(posedge clk); #1;
    a_conv(10'h1FF, n);
    chk("s_neg_511", 32'(a_neg), 32'd0);
    chk("s_bcd_511", 32'(a_bcd), 32'h0511);
    @(posedge clk); #1;
`endif

    // two-digit instance: overflow then a clean value
    b_conv(10'd255, n);
    chk("d2_lat_255", 32'(n), 32'd10);
    chk("d2_ovf_255", 32'(b_ovf), 32'd1);
    chk("d2_bcd_255", 32'(b_bcd), 32'h55);
    @(posedge clk); #1;
    b_conv(10'd99, n);
    chk("d2_ovf_99", 32'(b_ovf), 32'd0);
    chk("d2_bcd_99", 32'(b_bcd), 32'h99);
    chk("d2_neg_99", 32'(b_neg), 32'd0);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
